multi_channel_logic_analyzer: RTL and testbench

// - Parametrised successor to the single-input tiny logic analyzer: samples CHANNELS async inputs,

---
 rtl/tiny_la_pkg.sv | 5 +
 rtl/la_sample_buffer.sv | 20 ++
 rtl/multi_channel_logic_analyzer.sv | 102 ++++++++++
 tb/tb_multi_channel_logic_analyzer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tiny_la_pkg.sv
// tiny_la_pkg: state and trigger-mode codes shared by the logic analyzer
package tiny_la_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, CAPTURE = 2'b10, READOUT = 2'b11} la_state_e;
  typedef enum logic [1:0] {TRIG_RISE = 2'b00, TRIG_FALL = 2'b01, TRIG_ANY = 2'b10, TRIG_NOW = 2'b11} trig_mode_e;
endpackage

// File: rtl/la_sample_buffer.sv
// la_sample_buffer: unreset sample storage with one write port and a registered read port
module la_sample_buffer #(
  parameter int DEPTH = 16,
  parameter int W = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // storage write, deliberately without reset
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // registered read; only the output register clears on reset
  always_ff @(posedge clk) rdata <= rst ? '0 : mem[raddr];
endmodule

// File: rtl/multi_channel_logic_analyzer.sv
// multi_channel_logic_analyzer: edge-triggered, prescaled capture of CHANNELS probes with word-by-word readout
module multi_channel_logic_analyzer
  import tiny_la_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH = 16,
  parameter int PRESCALE_W = 8,
  parameter int SYNC_STAGES = 2,
  localparam int TW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   data_in,
  input  logic                  arm,
  input  logic [TW-1:0]         trig_ch,
  input  logic [1:0]            trig_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rd_next,
  output logic [CHANNELS-1:0]   rd_data,
  output logic                  rd_valid,
  output logic [1:0]            state,
  output logic                  done
);
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] s, p;
  logic [TW-1:0] sel;
  logic s_b, p_b, trig, sample_hit, last, we;
  logic [PRESCALE_W-1:0] cnt;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, waddr;
  la_state_e st;
  assign s = sync[SYNC_STAGES-1];
  assign state = st;
  // synchronizer chain plus one-clock history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      p <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], data_in};
      p <= s;
    end
  end
  // trigger selection, write port steering and next read address
  always_comb begin
    sel = (32'(trig_ch) < CHANNELS) ? trig_ch : '0;
    s_b = s[sel];
    p_b = p[sel];
    trig = trig_mode == TRIG_NOW ? 1'b1 :
           trig_mode == TRIG_ANY ? s_b ^ p_b :
           trig_mode == TRIG_FALL ? ~s_b & p_b : s_b & ~p_b;
    sample_hit = st == CAPTURE && cnt == prescale;
    last = sample_hit && wr_ptr == AW'(DEPTH - 1);
    we = (st == ARMED && trig) || sample_hit;
    waddr = st == ARMED ? '0 : wr_ptr;
    rd_ptr_nxt = last ? '0 : (st == READOUT && rd_next && !arm) ? rd_ptr + AW'(1) : rd_ptr;
  end
  // capture/readout sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      case (st)
        IDLE: if (arm) st <= ARMED;
        ARMED: if (trig) begin
          st <= CAPTURE;
          wr_ptr <= AW'(1);
          cnt <= '0;
        end
        CAPTURE: begin
          cnt <= sample_hit ? '0 : cnt + PRESCALE_W'(1);
          if (sample_hit) wr_ptr <= wr_ptr + AW'(1);
          if (last) begin
            st <= READOUT;
            rd_valid <= 1'b1;
            done <= 1'b1;
          end
        end
        READOUT: if (arm || (rd_next && rd_ptr == AW'(DEPTH - 1))) begin
          st <= arm ? ARMED : IDLE;
          rd_valid <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
  la_sample_buffer #(.DEPTH(DEPTH), .W(CHANNELS)) u_buf (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .raddr(rd_ptr_nxt),
    .wdata(s),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_multi_channel_logic_analyzer.sv
// tb_multi_channel_logic_analyzer: table-driven and randomized checks against a pin-history model
module tb_multi_channel_logic_analyzer;
  localparam int CH = 4, D = 16, PW = 8, SS = 2;
  logic clk = 0, rst = 1, arm = 0, rd_next = 0;
  logic [CH-1:0] data_in = '0;
  logic [1:0] trig_ch = '0, trig_mode = '0;
  logic [PW-1:0] prescale = '0;
  logic [CH-1:0] rd_data;
  logic rd_valid, done;
  logic [1:0] state;
  int total = 0, bad = 0;
  int ecnt = 0, pat = 4, a_edge = 0;
  logic [CH-1:0] pinh [0:19999];
  typedef struct {int md; int ch; int pre; int pt; int cap; int abort_w; int hold_w;} vec_t;
  vec_t tbl [5];

  multi_channel_logic_analyzer #(.CHANNELS(CH), .DEPTH(D), .PRESCALE_W(PW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .arm(arm), .trig_ch(trig_ch), .trig_mode(trig_mode),
    .prescale(prescale), .rd_next(rd_next), .rd_data(rd_data), .rd_valid(rd_valid), .state(state), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    pinh[ecnt] <= data_in;
    ecnt <= ecnt + 1;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CH-1:0] pat_val(input int n);
    case (pat)
      0: return CH'($urandom);
      1: return 4'b1010;
      2: return (n >= a_edge + 6) ? 4'b0010 : 4'b0000;
      3: return ((n / 8) % 2) ? 4'b0100 : 4'b0000;
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    data_in = pat_val(ecnt);
  endtask

  // synchronized value seen by the sequencer at edge k is the pin sampled SS edges earlier
  function automatic bit trig_at(input int k, input int md, input int ch);
    logic sv, pv;
    sv = pinh[k - SS][ch];
    pv = pinh[k - SS - 1][ch];
    case (md)
      0: return sv && !pv;
      1: return !sv && pv;
      2: return sv != pv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic do_reset();
    pat = 4;
    data_in = '0;
    rst = 1;
    repeat (3) step();
    rst = 0;
    repeat (3) step();
  endtask

  task automatic run_cap(input int md, input int ch, input int pre, input int pt, input int cap, input int abort_w, input int hold_w);
    int ccnt, r, t;
    trig_mode = 2'(md);
    trig_ch = 2'(ch);
    prescale = PW'(pre);
    pat = pt;
    a_edge = ecnt;
    arm = 1;
    step();
    arm = 0;
    chk("armed_after_arm", state, 2'b01);
    ccnt = 0;
    r = -1;
    for (int i = 0; i < 3000; i++) begin
      arm = (state == 2'b10 && ccnt == 2);
      step();
      if (state == 2'b10) ccnt++;
      if (state == 2'b11) begin
        r = ecnt - 1;
        break;
      end
    end
    arm = 0;
    if (r < 0) begin
      chk("readout_reached", 0, 1);
      return;
    end
    chk("capture_cycles", ccnt, cap);
    t = -1;
    for (int k = a_edge + 1; k <= r; k++) if (trig_at(k, md, ch)) begin
      t = k;
      break;
    end
    chk("readout_entry_edge", r, t + (D - 1) * (pre + 1));
    for (int j = 0; j < D; j++) begin
      if (j == hold_w) repeat (20) step();
      chk("rd_valid_in_readout", rd_valid, 1);
      chk("done_in_readout", done, 1);
      chk("rd_data_word", rd_data, pinh[t + j * (pre + 1) - SS]);
      if (j == abort_w) begin
        arm = 1;
        rd_next = 1;
        step();
        arm = 0;
        rd_next = 0;
        chk("abort_to_armed", state, 2'b01);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_done", done, 0);
        do_reset();
        return;
      end
      repeat ($urandom_range(0, 2)) step();
      rd_next = 1;
      step();
      rd_next = 0;
    end
    chk("idle_after_readout", state, 2'b00);
    chk("rd_valid_after_readout", rd_valid, 0);
    chk("done_after_readout", done, 0);
  endtask

  initial begin
    tbl[0] = '{0, 1, 0, 2, 15, -1, -1};
    tbl[1] = '{1, 2, 3, 3, 60, -1, -1};
    tbl[2] = '{3, 0, 0, 1, 15, -1, 3};
    tbl[3] = '{3, 0, 0, 1, 15, 5, -1};
    tbl[4] = '{2, 3, 1, 0, 30, -1, -1};
    rst = 1;
    repeat (10) step();
    chk("reset_state", state, 2'b00);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 0;
    repeat (3) step();
    rd_next = 1;
    repeat (3) step();
    rd_next = 0;
    chk("rd_next_idle_state", state, 2'b00);
    chk("rd_next_idle_valid", rd_valid, 0);
    for (int i = 0; i < 5; i++)
      run_cap(tbl[i].md, tbl[i].ch, tbl[i].pre, tbl[i].pt, tbl[i].cap, tbl[i].abort_w, tbl[i].hold_w);
    for (int i = 0; i < 6; i++) begin
      int pre = $urandom_range(0, 3);
      run_cap($urandom_range(0, 3), $urandom_range(0, 3), pre, 0, (D - 1) * (pre + 1), -1, -1);
    end
    trig_mode = 2'b11;
    prescale = 1;
    pat = 1;
    arm = 1;
    step();
    arm = 0;
    step();
    chk("capture_after_immediate", state, 2'b10);
    repeat (12) step();
    chk("still_capturing_at_7", state, 2'b10);
    rst = 1;
    step();
    chk("mid_capture_reset_state", state, 2'b00);
    chk("mid_capture_reset_valid", rd_valid, 0);
    chk("mid_capture_reset_done", done, 0);
    rst = 0;
    pat = 4;
    repeat (3) step();
    run_cap(3, 0, 1, 0, 30, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
